// File: rtl/axi_ar_beat_gen_if.sv
// AR request + per-beat address stream bundle for axi_ar_beat_gen.
// slave = the beat generator's view, master = the requester/consumer view.
interface axi_ar_beat_gen_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int ID_WIDTH   = 4
);
  logic [ID_WIDTH-1:0]   s_arid;
  logic [ADDR_WIDTH-1:0] s_araddr;
  logic [7:0]            s_arlen;
  logic [2:0]            s_arsize;
  logic [1:0]            s_arburst;
  logic                  s_arvalid;
  logic                  s_arready;
  logic [ADDR_WIDTH-1:0] m_addr;
  logic [ID_WIDTH-1:0]   m_id;
  logic                  m_last;
  logic                  m_valid;
  logic                  m_ready;
  logic                  busy;

  modport slave (
    input  s_arid, s_araddr, s_arlen, s_arsize, s_arburst, s_arvalid, m_ready,
    output s_arready, m_addr, m_id, m_last, m_valid, busy
  );

  modport master (
    output s_arid, s_araddr, s_arlen, s_arsize, s_arburst, s_arvalid, m_ready,
    input  s_arready, m_addr, m_id, m_last, m_valid, busy
  );
endinterface

// File: rtl/axi_ar_beat_gen.sv
// AXI4 AR burst-to-beat expander: one address per data beat on a valid/ready stream.
// WRAP bursts are expanded only when AXI_AR_BEAT_GEN_WRAP_EN is defined; otherwise WRAP runs as INCR.
module axi_ar_beat_gen #(
  parameter int ADDR_WIDTH = 16,
  parameter int ID_WIDTH   = 4,
  parameter int MAX_SIZE   = 3
) (
  input logic clk,
  input logic rst,
  axi_ar_beat_gen_if.slave bus
);
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] BURST = 1'b1;
  localparam logic [ADDR_WIDTH-1:0] ONE = ADDR_WIDTH'(1);

  typedef struct packed {
    logic [ID_WIDTH-1:0]   id;
    logic [ADDR_WIDTH-1:0] addr;
    logic [2:0]            size;
    logic                  fixed;
    logic [7:0]            rem;
`ifdef AXI_AR_BEAT_GEN_WRAP_EN
    logic                  wrap;
    logic [7:0]            len;
`endif
  } ctx_t;

  logic [0:0] state;
  ctx_t ctx;

  logic [2:0]            size_in;
  logic [ADDR_WIDTH-1:0] step, aligned, incr, next_addr;

  assign size_in = (bus.s_arsize > 3'(MAX_SIZE)) ? 3'(MAX_SIZE) : bus.s_arsize;
  assign step    = ONE << ctx.size;
  assign aligned = ctx.addr & ~(step - ONE);
  assign incr    = aligned + step;

`ifdef AXI_AR_BEAT_GEN_WRAP_EN
  logic [ADDR_WIDTH-1:0] wrap_bytes, boundary;
  logic                  wrap_in;
  assign wrap_bytes = (ADDR_WIDTH'(ctx.len) + ONE) << ctx.size;
  assign boundary   = ctx.addr & ~(wrap_bytes - ONE);
  // Only power-of-two beat counts form a legal wrap window; anything else degrades to INCR.
  assign wrap_in    = (bus.s_arburst == 2'b10) &&
                      (bus.s_arlen == 8'd1 || bus.s_arlen == 8'd3 ||
                       bus.s_arlen == 8'd7 || bus.s_arlen == 8'd15);
`endif

  always_comb begin
    next_addr = incr;
    if (ctx.fixed) next_addr = ctx.addr;
`ifdef AXI_AR_BEAT_GEN_WRAP_EN
    else if (ctx.wrap) next_addr = boundary + ((incr - boundary) & (wrap_bytes - ONE));
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ctx   <= '0;
    end else begin
      case (state)
        IDLE: if (bus.s_arvalid) begin
          state     <= BURST;
          ctx.id    <= bus.s_arid;
          ctx.addr  <= bus.s_araddr;
          ctx.size  <= size_in;
          ctx.fixed <= (bus.s_arburst == 2'b00);
          ctx.rem   <= bus.s_arlen;
`ifdef AXI_AR_BEAT_GEN_WRAP_EN
          ctx.wrap  <= wrap_in;
          ctx.len   <= bus.s_arlen;
`endif
        end
        BURST: if (bus.m_ready) begin
          if (ctx.rem == 8'd0) begin
            state <= IDLE;
          end else begin
            ctx.addr <= next_addr;
            ctx.rem  <= ctx.rem - 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.s_arready = (state == IDLE);
  assign bus.m_valid   = (state == BURST);
  assign bus.busy      = (state == BURST);
  assign bus.m_last    = (state == BURST) && (ctx.rem == 8'd0);
  assign bus.m_addr    = ctx.addr;
  assign bus.m_id      = ctx.id;
endmodule

// File: tb/tb_axi_ar_beat_gen.sv
// Bench for axi_ar_beat_gen: directed vector table, hand-built stall/reset sequences,
// and random bursts checked against an arithmetic beat-address model.
module tb_axi_ar_beat_gen;
  localparam int AW = 16;
  localparam int IW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axi_ar_beat_gen_if #(.ADDR_WIDTH(AW), .ID_WIDTH(IW)) bus ();
  axi_ar_beat_gen #(.ADDR_WIDTH(AW), .ID_WIDTH(IW), .MAX_SIZE(3)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int compared   = 0;
  int mismatched = 0;
  logic [15:0] exp_q[$];

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    int          n;
    logic [15:0] exp[4];
  } vec_t;
  vec_t tbl[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Address of beat i, straight from the burst rules.
  function automatic logic [15:0] model_addr(input int a, input int len, input int size,
                                             input int burst, input int i);
    int sz, bytes, al;
    sz    = (size > 3) ? 3 : size;
    bytes = 1 << sz;
    al    = (a / bytes) * bytes;
    if (i == 0) return 16'(a);
    if (burst == 0) return 16'(a);
`ifdef AXI_AR_BEAT_GEN_WRAP_EN
    if (burst == 2 && (len == 1 || len == 3 || len == 7 || len == 15)) begin
      int wb, bnd;
      wb  = (len + 1) * bytes;
      bnd = (a / wb) * wb;
      return 16'(bnd + ((al + i * bytes - bnd) % wb));
    end
`endif
    return 16'(al + i * bytes);
  endfunction

  task automatic idle_check(input string tag);
    chk({tag, "_arready"}, 32'(bus.s_arready), 32'd1);
    chk({tag, "_valid"},   32'(bus.m_valid),   32'd0);
    chk({tag, "_busy"},    32'(bus.busy),      32'd0);
  endtask

  // Issue one AR burst and check every beat against exp_q.
  task automatic run_burst(input logic [15:0] a, input logic [7:0] len, input logic [2:0] size,
                           input logic [1:0] burst, input logic [3:0] id,
                           input int stall_beat, input int stall_n, input bit rnd_ready);
    bus.s_arid    = id;
    bus.s_araddr  = a;
    bus.s_arlen   = len;
    bus.s_arsize  = size;
    bus.s_arburst = burst;
    bus.s_arvalid = 1'b1;
    bus.m_ready   = 1'b1;
    chk("ar_ready_idle", 32'(bus.s_arready), 32'd1);
    tick;
    bus.s_arvalid = 1'b0;
    bus.s_araddr  = 16'($urandom);
    bus.s_arid    = 4'($urandom);
    bus.s_arlen   = 8'($urandom);
    for (int i = 0; i <= int'(len); i++) begin
      int waited;
      bit done;
      waited = 0;
      done   = 1'b0;
      while (!done) begin
        logic r;
        r = 1'b1;
        if (i == stall_beat && waited < stall_n) r = 1'b0;
        else if (rnd_ready && waited < 6 && $urandom_range(0, 3) == 0) r = 1'b0;
        bus.m_ready = r;
        chk("beat_valid",   32'(bus.m_valid),   32'd1);
        chk("beat_addr",    32'(bus.m_addr),    32'(exp_q[i]));
        chk("beat_last",    32'(bus.m_last),    32'(i == int'(len)));
        chk("beat_id",      32'(bus.m_id),      32'(id));
        chk("beat_arready", 32'(bus.s_arready), 32'd0);
        chk("beat_busy",    32'(bus.busy),      32'd1);
        tick;
        waited++;
        done = r;
      end
    end
    bus.m_ready = 1'b1;
    idle_check("post_burst");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{16'h0100, 8'd3, 3'd2, 2'b01, 4, '{16'h0100, 16'h0104, 16'h0108, 16'h010C}};
    tbl[1] = '{16'h0040, 8'd2, 3'd2, 2'b00, 3, '{16'h0040, 16'h0040, 16'h0040, 16'h0000}};
    tbl[2] = '{16'h0200, 8'd0, 3'd1, 2'b01, 1, '{16'h0200, 16'h0000, 16'h0000, 16'h0000}};
    tbl[3] = '{16'hFFFC, 8'd1, 3'd2, 2'b01, 2, '{16'hFFFC, 16'h0000, 16'h0000, 16'h0000}};
`ifdef AXI_AR_BEAT_GEN_WRAP_EN
    tbl[4] = '{16'h0038, 8'd3, 3'd2, 2'b10, 4, '{16'h0038, 16'h003C, 16'h0030, 16'h0034}};
`else
    tbl[4] = '{16'h0038, 8'd3, 3'd2, 2'b10, 4, '{16'h0038, 16'h003C, 16'h0040, 16'h0044}};
`endif
    tbl[5] = '{16'h0010, 8'd1, 3'd7, 2'b01, 2, '{16'h0010, 16'h0018, 16'h0000, 16'h0000}};
    tbl[6] = '{16'h0001, 8'd1, 3'd0, 2'b11, 2, '{16'h0001, 16'h0002, 16'h0000, 16'h0000}};

    bus.s_arid = '0; bus.s_araddr = '0; bus.s_arlen = '0; bus.s_arsize = '0;
    bus.s_arburst = '0; bus.s_arvalid = 1'b0; bus.m_ready = 1'b1;
    rst = 1'b1;
    repeat (3) tick;
    rst = 1'b0;
    chk("reset_addr", 32'(bus.m_addr), 32'd0);
    chk("reset_id",   32'(bus.m_id),   32'd0);
    chk("reset_last", 32'(bus.m_last), 32'd0);
    for (int c = 0; c < 10; c++) begin
      idle_check("idle");
      tick;
    end

    for (int v = 0; v < 7; v++) begin
      exp_q.delete();
      for (int j = 0; j < tbl[v].n; j++) exp_q.push_back(tbl[v].exp[j]);
      run_burst(tbl[v].addr, tbl[v].len, tbl[v].size, tbl[v].burst, 4'(v + 1), -1, 0, 1'b0);
    end

    // Unaligned start, second beat held off for three cycles.
    exp_q.delete();
    exp_q.push_back(16'h0103); exp_q.push_back(16'h0104); exp_q.push_back(16'h0108);
    run_burst(16'h0103, 8'd2, 3'd2, 2'b01, 4'hA, 1, 3, 1'b0);

    // Reset while the second beat of an 8-beat burst is on the bus.
    bus.s_arid = 4'h5; bus.s_araddr = 16'h0500; bus.s_arlen = 8'd7;
    bus.s_arsize = 3'd2; bus.s_arburst = 2'b01; bus.s_arvalid = 1'b1; bus.m_ready = 1'b1;
    tick;
    bus.s_arvalid = 1'b0;
    chk("rst_seq_beat0", 32'(bus.m_addr), 32'h0500);
    tick;
    chk("rst_seq_beat1", 32'(bus.m_addr), 32'h0504);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    idle_check("after_rst");
    chk("after_rst_addr", 32'(bus.m_addr), 32'd0);
    chk("after_rst_id",   32'(bus.m_id),   32'd0);
    chk("after_rst_last", 32'(bus.m_last), 32'd0);
    tick;
    idle_check("after_rst2");

    // Full 256-beat burst to exercise the 8-bit counter.
    exp_q.delete();
    for (int i = 0; i < 256; i++) exp_q.push_back(model_addr(16'h1000, 255, 0, 1, i));
    run_burst(16'h1000, 8'd255, 3'd0, 2'b01, 4'h3, -1, 0, 1'b0);

    for (int n = 0; n < 40; n++) begin
      int a, len, size, burst;
      a     = int'($urandom_range(0, 16'hFFFF));
      len   = ($urandom_range(0, 2) == 0) ? ((2 << $urandom_range(0, 3)) - 1)
                                          : int'($urandom_range(0, 20));
      size  = int'($urandom_range(0, 5));
      burst = int'($urandom_range(0, 3));
      exp_q.delete();
      for (int i = 0; i <= len; i++) exp_q.push_back(model_addr(a, len, size, burst, i));
      run_burst(16'(a), 8'(len), 3'(size), 2'(burst), 4'($urandom), -1, 0, 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
